// File: rtl/data_path_param.sv
// data_path_param: IR, PC, register file, ALU and flags; define DP_MUL_EN to add the iterative multiplier
module data_path_param #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch,
  input  logic              pc_enable,
  input  logic              ir_enable,
  input  logic              addr_sel,
  input  logic              c_sel,
  input  logic [2:0]        operation,
  input  logic              alu_start,
  input  logic              write_reg_enable,
  input  logic              flags_reg_enable,
  output logic [7:0]        opcode,
  output logic              alu_busy,
  output logic              alu_done,
  output logic              zero_op,
  output logic              neg_op,
  output logic              unsigned_overflow,
  output logic              signed_overflow,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in
);
  localparam int RW = $clog2(REG_N);
  logic [ADDR_W-1:0] pc, mem_addr;
  logic [DATA_W-1:0] ir, bus_a, bus_b, bus_c, alu_out, res, addend;
  logic [DATA_W-1:0] regs [REG_N];
  logic [RW-1:0] a_addr, b_addr, c_addr;
  logic [DATA_W:0] sum;
  logic is_ld, is_st, is_mv, is_alu, sub, arith, c_comb, v_comb, carry, sov, unused_ir;
  assign opcode = ir[DATA_W-1 -: 8];
  assign is_ld = opcode == 8'h81;
  assign is_st = opcode == 8'h82;
  assign is_mv = opcode == 8'h91;
  assign is_alu = opcode >= 8'hA1 && opcode <= 8'hA6;
  assign a_addr = is_st ? ir[ADDR_W+RW-1:ADDR_W] : (is_mv || is_alu) ? ir[RW-1:0] : '0;
  assign b_addr = is_mv ? ir[RW-1:0] : is_alu ? ir[2*RW-1:RW] : '0;
  assign c_addr = is_ld ? ir[ADDR_W+RW-1:ADDR_W] : is_mv ? ir[2*RW-1:RW] : is_alu ? ir[3*RW-1:2*RW] : '0;
  assign mem_addr = (is_ld || is_st || is_mv || opcode[7:4] == 4'h0) ? ir[ADDR_W-1:0] : '0;
  assign unused_ir = ^ir;
  assign bus_a = regs[a_addr];
  assign bus_b = regs[b_addr];
  assign bus_c = c_sel ? data_in : alu_out;
  assign data_out = bus_a;
  assign ram_addr = addr_sel ? mem_addr : pc;
  // SUB computes b - a as b + ~a + 1 so one adder serves both
  always_comb begin
    sub = operation == 3'b001;
    arith = operation[2:1] == 2'b00;
    addend = sub ? ~bus_a : bus_a;
    sum = {1'b0, bus_b} + {1'b0, addend} + {{DATA_W{1'b0}}, sub};
    res = arith ? sum[DATA_W-1:0] :
          operation == 3'b010 ? (bus_a & bus_b) :
          operation == 3'b011 ? (bus_a | bus_b) :
          operation == 3'b100 ? (bus_a ^ bus_b) : '0;
    c_comb = arith & sum[DATA_W];
    v_comb = arith & (sum[DATA_W] ^ bus_b[DATA_W-1] ^ addend[DATA_W-1] ^ sum[DATA_W-1]);
  end
`ifdef DP_MUL_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
  localparam int CW = $clog2(DATA_W);
  mul_state_t state;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0] mcand;
  logic [CW-1:0] cnt;
  logic [DATA_W:0] step;
  assign step = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, mcand} : '0);
  // operands are captured at start, so register writes during RUN cannot disturb the product
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prod <= '0;
      mcand <= '0;
      cnt <= '0;
    end else if (state == IDLE && alu_start && operation == 3'b101) begin
      state <= RUN;
      mcand <= bus_a;
      prod <= {{DATA_W{1'b0}}, bus_b};
      cnt <= '0;
    end else if (state == RUN) begin
      prod <= {step, prod[DATA_W-1:1]};
      cnt <= cnt + 1'b1;
      if (cnt == CW'(DATA_W - 1)) state <= DONE;
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
  assign alu_busy = state == RUN;
  assign alu_done = !rst && ((state == IDLE && alu_start && operation != 3'b101) || state == DONE);
  assign alu_out = state == DONE ? prod[DATA_W-1:0] : res;
  assign carry = state == DONE ? |prod[2*DATA_W-1:DATA_W] : c_comb;
  assign sov = state == DONE ? 1'b0 : v_comb;
`else
  assign alu_busy = 1'b0;
  assign alu_done = !rst && alu_start;
  assign alu_out = res;
  assign carry = c_comb;
  assign sov = v_comb;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      ir <= '0;
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
      zero_op <= 1'b0;
      neg_op <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow <= 1'b0;
    end else begin
      if (pc_enable) pc <= branch ? mem_addr : pc + 1'b1;
      if (ir_enable) ir <= data_in;
      if (write_reg_enable) regs[c_addr] <= bus_c;
      if (flags_reg_enable) begin
        zero_op <= ~|alu_out;
        neg_op <= alu_out[DATA_W-1];
        unsigned_overflow <= carry;
        signed_overflow <= sov;
      end
    end
  end
endmodule

// File: tb/tb_data_path_param.sv
// tb_data_path_param: directed self-checking bench for data_path_param
module tb_data_path_param;
  logic clk = 0, rst = 0, branch = 0, pc_enable = 0, ir_enable = 0, addr_sel = 0, c_sel = 0;
  logic alu_start = 0, wre = 0, fre = 0;
  logic [2:0] operation = 0;
  logic [15:0] data_in = 0, data_out, v;
  logic [7:0] opcode;
  logic [4:0] ram_addr;
  logic alu_busy, alu_done, zero_op, neg_op, unsigned_overflow, signed_overflow, d;
  int checks = 0, errors = 0;
  data_path_param #(.DATA_W(16), .REG_N(4), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
    .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation), .alu_start(alu_start),
    .write_reg_enable(wre), .flags_reg_enable(fre), .opcode(opcode), .alu_busy(alu_busy),
    .alu_done(alu_done), .zero_op(zero_op), .neg_op(neg_op),
    .unsigned_overflow(unsigned_overflow), .signed_overflow(signed_overflow),
    .ram_addr(ram_addr), .data_out(data_out), .data_in(data_in));
  always #5 clk = ~clk;
  task tick; @(posedge clk); #1; endtask
  task set_ir(input logic [15:0] x);
    data_in = x; ir_enable = 1; tick(); ir_enable = 0;
  endtask
  task write_reg(input int r, input logic [15:0] x);
    set_ir(16'h8100 | 16'(r << 5)); data_in = x; c_sel = 1; wre = 1; tick(); wre = 0; c_sel = 0;
  endtask
  task read_reg(input int r, output logic [15:0] x);
    set_ir(16'h8200 | 16'(r << 5)); #1 x = data_out;
  endtask
  task alu_op(input logic [2:0] op, output logic done);
    set_ir(16'hA139); operation = op; alu_start = 1; #1 done = alu_done;
    c_sel = 0; wre = 1; fre = 1; tick(); alu_start = 0; wre = 0; fre = 0;
  endtask
  task test_reset;
    rst = 1; branch = 1; pc_enable = 1; ir_enable = 1; addr_sel = 1; c_sel = 1;
    alu_start = 1; wre = 1; fre = 1; data_in = 16'hFFFF; operation = 3'b000;
    tick(); tick(); #1;
    checks++; if (alu_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", alu_done); end
    checks++; if (alu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", alu_busy); end
    checks++; if (opcode !== 8'h00) begin errors++; $display("FAIL reset_opcode: got %h expected 00", opcode); end
    checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL reset_data_out: got %h expected 0000", data_out); end
    checks++; if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b0)
      begin errors++; $display("FAIL reset_flags: got %b expected 0000", {zero_op, neg_op, unsigned_overflow, signed_overflow}); end
    rst = 0; branch = 0; pc_enable = 0; ir_enable = 0; addr_sel = 0; c_sel = 0;
    alu_start = 0; wre = 0; fre = 0; #1;
    checks++; if (ram_addr !== 5'd0) begin errors++; $display("FAIL reset_pc: got %h expected 00", ram_addr); end
    for (int r = 0; r < 4; r++) begin
      read_reg(r, v);
      checks++; if (v !== 16'h0) begin errors++; $display("FAIL reset_reg%0d: got %h expected 0000", r, v); end
    end
  endtask
  task test_add;
    write_reg(1, 16'h7FFF); write_reg(2, 16'h0001); alu_op(3'b000, d);
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL add_done: got %b expected 1", d); end
    checks++; if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b0101)
      begin errors++; $display("FAIL add_flags: got %b expected 0101", {zero_op, neg_op, unsigned_overflow, signed_overflow}); end
    read_reg(3, v);
    checks++; if (v !== 16'h8000) begin errors++; $display("FAIL add_result: got %h expected 8000", v); end
  endtask
  task test_sub;
    write_reg(1, 16'h0005); write_reg(2, 16'h0005); alu_op(3'b001, d);
    checks++; if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b1010)
      begin errors++; $display("FAIL sub_flags: got %b expected 1010", {zero_op, neg_op, unsigned_overflow, signed_overflow}); end
    read_reg(3, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL sub_result: got %h expected 0000", v); end
    write_reg(1, 16'h0007); alu_op(3'b001, d);
    read_reg(3, v);
    checks++; if (v !== 16'hFFFE) begin errors++; $display("FAIL sub_order: got %h expected fffe", v); end
  endtask
  task test_logic;
    write_reg(1, 16'hF0F0); write_reg(2, 16'h0FF0); alu_op(3'b010, d);
    checks++; if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b0000)
      begin errors++; $display("FAIL and_flags: got %b expected 0000", {zero_op, neg_op, unsigned_overflow, signed_overflow}); end
    read_reg(3, v);
    checks++; if (v !== 16'h00F0) begin errors++; $display("FAIL and_result: got %h expected 00f0", v); end
    alu_op(3'b100, d);
    read_reg(3, v);
    checks++; if (v !== 16'hFF00) begin errors++; $display("FAIL xor_result: got %h expected ff00", v); end
    checks++; if (neg_op !== 1'b1) begin errors++; $display("FAIL xor_neg: got %b expected 1", neg_op); end
    alu_op(3'b011, d);
    read_reg(3, v);
    checks++; if (v !== 16'hFFF0) begin errors++; $display("FAIL or_result: got %h expected fff0", v); end
  endtask
`ifdef DP_MUL_EN
  task test_mul;
    int busy_n, done_at;
    busy_n = 0; done_at = 0;
    write_reg(1, 16'h0100); write_reg(2, 16'h0300); set_ir(16'hA139);
    operation = 3'b101; alu_start = 1; #1;
    checks++; if (alu_done !== 1'b0) begin errors++; $display("FAIL mul_start_done: got %b expected 0", alu_done); end
    tick(); alu_start = 0;
    for (int i = 1; i <= 40 && done_at == 0; i++) begin
      if (alu_done) begin done_at = i; wre = 1; fre = 1; end
      else if (alu_busy) busy_n++;
      tick(); wre = 0; fre = 0;
    end
    checks++; if (done_at != 17) begin errors++; $display("FAIL mul_latency: got %0d expected 17", done_at); end
    checks++; if (busy_n != 16) begin errors++; $display("FAIL mul_busy: got %0d expected 16", busy_n); end
    checks++; if ({zero_op, unsigned_overflow, signed_overflow} !== 3'b110)
      begin errors++; $display("FAIL mul_flags: got %b expected 110", {zero_op, unsigned_overflow, signed_overflow}); end
    read_reg(3, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL mul_result: got %h expected 0000", v); end
  endtask
  task test_back_to_back;
    int dones, done_at;
    dones = 0; done_at = 0;
    write_reg(1, 16'h0003); write_reg(2, 16'h0005); set_ir(16'hA139);
    operation = 3'b101; alu_start = 1; tick(); alu_start = 0;
    set_ir(16'h8120); data_in = 16'h00FF; c_sel = 1; wre = 1; tick(); wre = 0; c_sel = 0;
    checks++; if (alu_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", alu_busy); end
    alu_start = 1; tick(); alu_start = 0;
    set_ir(16'hA139);
    for (int i = 5; i <= 40; i++) begin
      if (alu_done) begin dones++; if (done_at == 0) done_at = i; wre = 1; fre = 1; end
      tick(); wre = 0; fre = 0;
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL b2b_dones: got %0d expected 1", dones); end
    checks++; if (done_at != 17) begin errors++; $display("FAIL b2b_latency: got %0d expected 17", done_at); end
    checks++; if ({zero_op, unsigned_overflow} !== 2'b00)
      begin errors++; $display("FAIL b2b_flags: got %b expected 00", {zero_op, unsigned_overflow}); end
    read_reg(3, v);
    checks++; if (v !== 16'h000F) begin errors++; $display("FAIL b2b_result: got %h expected 000f", v); end
    read_reg(1, v);
    checks++; if (v !== 16'h00FF) begin errors++; $display("FAIL b2b_r1: got %h expected 00ff", v); end
  endtask
  task test_mul_reset;
    int dones;
    dones = 0;
    write_reg(1, 16'h0003); write_reg(2, 16'h0005); set_ir(16'hA139);
    operation = 3'b101; alu_start = 1; tick(); alu_start = 0; tick(); tick();
    rst = 1; tick(); rst = 0; #1;
    checks++; if (alu_busy !== 1'b0) begin errors++; $display("FAIL mulrst_busy: got %b expected 0", alu_busy); end
    for (int i = 0; i < 30; i++) begin
      if (alu_done) dones++;
      tick();
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL mulrst_dones: got %0d expected 0", dones); end
  endtask
`else
  task test_reserved;
    write_reg(1, 16'h0003); write_reg(2, 16'h0005); alu_op(3'b101, d);
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL rsv_done: got %b expected 1", d); end
    checks++; if (alu_busy !== 1'b0) begin errors++; $display("FAIL rsv_busy: got %b expected 0", alu_busy); end
    checks++; if ({zero_op, unsigned_overflow, signed_overflow} !== 3'b100)
      begin errors++; $display("FAIL rsv_flags: got %b expected 100", {zero_op, unsigned_overflow, signed_overflow}); end
    read_reg(3, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rsv_result: got %h expected 0000", v); end
    alu_op(3'b000, d); alu_op(3'b110, d);
    read_reg(3, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rsv110_result: got %h expected 0000", v); end
  endtask
`endif
  task test_pc;
    rst = 1; tick(); rst = 0;
    pc_enable = 1; repeat (31) tick(); pc_enable = 0; #1;
    checks++; if (ram_addr !== 5'd31) begin errors++; $display("FAIL pc_31: got %h expected 1f", ram_addr); end
    pc_enable = 1; tick(); pc_enable = 0; #1;
    checks++; if (ram_addr !== 5'd0) begin errors++; $display("FAIL pc_wrap: got %h expected 00", ram_addr); end
    set_ir(16'h0114); #1;
    checks++; if (opcode !== 8'h01) begin errors++; $display("FAIL br_opcode: got %h expected 01", opcode); end
    branch = 1; pc_enable = 1; tick(); branch = 0; pc_enable = 0; #1;
    checks++; if (ram_addr !== 5'h14) begin errors++; $display("FAIL br_pc: got %h expected 14", ram_addr); end
    set_ir(16'h0107); addr_sel = 1; #1;
    checks++; if (ram_addr !== 5'h07) begin errors++; $display("FAIL addr_sel_mem: got %h expected 07", ram_addr); end
    addr_sel = 0; #1;
    checks++; if (ram_addr !== 5'h14) begin errors++; $display("FAIL addr_sel_pc: got %h expected 14", ram_addr); end
  endtask
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
`ifdef DP_MUL_EN
    test_mul();
    test_back_to_back();
    test_mul_reset();
`else
    test_reserved();
`endif
    test_pc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
